// File: rtl/tristate_bus_arbiter_if.sv
// Requester-side and arbiter-side signal bundle for the shared tri-state pad bus.
interface tristate_bus_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic               force_z;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      bus_i;
  logic               bus_t;
  logic               busy;

  modport master (
    output req, din, force_z,
    input  gnt, bus_i, bus_t, busy
  );

  modport slave (
    input  req, din, force_z,
    output gnt, bus_i, bus_t, busy
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared OBUFT bank, with a high-Z turnaround
// gap after every release and an optional cap on consecutive drive cycles.
module tristate_bus_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TURN    = 1,
  parameter int unsigned MAXHOLD = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  tristate_bus_arbiter_if.slave bus
);
  localparam int unsigned OW = $clog2(NREQ);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [7:0]      hold_q, hold_d;
  logic [3:0]      turn_q, turn_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            bus_t_q, bus_t_d;

  logic [OW-1:0]   sel;
  logic            sel_valid;
  int unsigned     idx;
  logic            release_now;
  logic [DW-1:0]   owner_data;

  // First requester after the last owner wins, so the previous owner goes last.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_valid && bus.req[OW'(idx)]) begin
        sel       = OW'(idx);
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    release_now = !bus.req[owner_q] || bus.force_z ||
                  ((MAXHOLD != 0) && (hold_q == 8'(MAXHOLD)));
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    bus_t_d = bus_t_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d   = '0;
        bus_t_d = 1'b1;
        if (!bus.force_z && sel_valid) begin
          state_d      = ST_DRIVE;
          gnt_d[sel]   = 1'b1;
          bus_t_d      = 1'b0;
          owner_d      = sel;
          last_d       = sel;
          hold_d       = 8'd1;
        end
      end
      ST_DRIVE: begin
        if (release_now) begin
          gnt_d   = '0;
          bus_t_d = 1'b1;
          if (TURN != 0) begin
            state_d = ST_TURN;
            turn_d  = 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_TURN: begin
        gnt_d   = '0;
        bus_t_d = 1'b1;
        if (turn_q == 4'(TURN)) state_d = ST_IDLE;
        else                    turn_d  = turn_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      hold_q  <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      bus_t_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      bus_t_q <= bus_t_d;
    end
  end

  // Zero-latency data path; gated by the registered grant so a non-owner never leaks.
  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) owner_data = bus.din[i*DW +: DW];
    end
  end

  assign bus.bus_i = (|gnt_q) ? owner_data : '0;
  assign bus.gnt   = gnt_q;
  assign bus.bus_t = bus_t_q;
  assign bus.busy  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: two builds (TURN=1/MAXHOLD=16 and TURN=0/MAXHOLD=0)
// checked against a cycle model of owner / gap / round-robin pointer.
module tb_tristate_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.NREQ(4), .DW(8)) ifa ();
  tristate_bus_arbiter_if #(.NREQ(4), .DW(8)) ifb ();

  tristate_bus_arbiter #(.NREQ(4), .DW(8), .TURN(1), .MAXHOLD(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  tristate_bus_arbiter #(.NREQ(4), .DW(8), .TURN(0), .MAXHOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  // owner = -1 means nobody drives; gap = remaining turnaround cycles.
  typedef struct {
    int owner;
    int held;
    int gap;
    int last;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t s, logic [3:0] r, logic f, int turn, int mh);
    mdl_t n;
    bit   found;
    n     = s;
    found = 0;
    if (s.owner >= 0) begin
      if (!r[s.owner] || f || (mh != 0 && s.held == mh)) begin
        n.owner = -1;
        n.gap   = turn;
      end else if (s.held < 255) begin
        n.held = s.held + 1;
      end
    end else if (s.gap > 0) begin
      n.gap = s.gap - 1;
    end else if (!f && r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        if (!found && r[(s.last + k) % 4]) begin
          found   = 1;
          n.owner = (s.last + k) % 4;
        end
      end
      n.last = n.owner;
      n.held = 1;
    end
    return n;
  endfunction

  // {gnt, bus_t, busy, bus_i}
  function automatic logic [13:0] expv(mdl_t s, logic [31:0] d);
    logic [3:0] g;
    logic [7:0] b;
    g = '0;
    b = '0;
    if (s.owner >= 0) begin
      g[s.owner] = 1'b1;
      b = d[s.owner*8 +: 8];
    end
    return {g, (s.owner < 0), (s.owner >= 0 || s.gap > 0), b};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{owner: -1, held: 0, gap: 0, last: 3};
      mb <= '{owner: -1, held: 0, gap: 0, last: 3};
    end else begin
      ma <= step(ma, ifa.req, ifa.force_z, 1, 16);
      mb <= step(mb, ifb.req, ifb.force_z, 0, 0);
    end
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    ifa.req     = '0;
    ifa.din     = '0;
    ifa.force_z = 1'b0;
    ifb.req     = '0;
    ifb.din     = '0;
    ifb.force_z = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] act;
    ifa.req = '0; ifa.din = '0; ifa.force_z = 1'b0;
    ifb.req = '0; ifb.din = '0; ifb.force_z = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    act = {ifa.gnt, ifa.bus_t, ifa.busy, ifa.bus_i};
    checks++;
    if (act !== 14'b0000_1_0_00000000) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", act, 14'b0000_1_0_00000000);
    end
    do_reset();
    ifa.req = 4'b0001;
    ifa.din = 32'h11223344;
    repeat (3) @(negedge clk);
    checks++;
    if (ifa.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_pre_drive: got %b expected %b", ifa.gnt, 4'b0001);
    end
    #2 rst_n = 1'b0;
    #1;
    act = {ifa.gnt, ifa.bus_t, ifa.busy, ifa.bus_i};
    checks++;
    if (act !== 14'b0000_1_0_00000000) begin
      errors++;
      $display("FAIL reset_mid_drive: got %h expected %h", act, 14'b0000_1_0_00000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ifa.gnt !== 4'b0001 || ifa.bus_t !== 1'b0) begin
      errors++;
      $display("FAIL reset_regrant: got %b/%b expected 0001/0", ifa.gnt, ifa.bus_t);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g [100];
    logic [3:0] run_v [$];
    int         run_l [$];
    logic [3:0] exp_v [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001};
    int         exp_l [9] = '{16, 2, 16, 2, 16, 2, 16, 2, 16};
    logic [13:0] act;
    do_reset();
    ifa.req = 4'b1111;
    ifa.din = $urandom;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      act = {ifa.gnt, ifa.bus_t, ifa.busy, ifa.bus_i};
      checks++;
      if (act !== expv(ma, ifa.din)) begin
        errors++;
        $display("FAIL rr_model cyc %0d: got %h expected %h", c, act, expv(ma, ifa.din));
      end
      g[c]    = ifa.gnt;
      ifa.din = $urandom;
    end
    for (int c = 0; c < 100; c++) begin
      if (c == 0 || g[c] !== g[c-1]) begin
        run_v.push_back(g[c]);
        run_l.push_back(1);
      end else begin
        run_l[run_l.size()-1]++;
      end
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= run_v.size() || run_v[i] !== exp_v[i] || run_l[i] != exp_l[i]) begin
        errors++;
        if (i < run_v.size())
          $display("FAIL rr_run %0d: got %b x%0d expected %b x%0d",
                   i, run_v[i], run_l[i], exp_v[i], exp_l[i]);
        else
          $display("FAIL rr_run %0d: got none expected %b x%0d", i, exp_v[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] exp_g [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000,
                              4'b0000, 4'b1000, 4'b1000, 4'b1000};
    logic [13:0] act;
    do_reset();
    ifa.req = 4'b0100;
    ifa.din = $urandom;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      act = {ifa.gnt, ifa.bus_t, ifa.busy, ifa.bus_i};
      checks++;
      if (ifa.gnt !== exp_g[c] || ifa.bus_t !== (exp_g[c] == 4'b0000)) begin
        errors++;
        $display("FAIL early_release cyc %0d: got %b/%b expected %b", c, ifa.gnt, ifa.bus_t, exp_g[c]);
      end
      checks++;
      if (act !== expv(ma, ifa.din)) begin
        errors++;
        $display("FAIL early_model cyc %0d: got %h expected %h", c, act, expv(ma, ifa.din));
      end
      if (c == 0) ifa.req = 4'b1100;
      if (c == 2) ifa.req = 4'b1000;
    end
  endtask

  task automatic test_data_path();
    logic [7:0] exp_b;
    do_reset();
    ifa.din = 32'hFFFF_A5FF;
    ifa.req = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_b = (c < 3) ? 8'hA5 : 8'h00;
      checks++;
      if (ifa.bus_i !== exp_b) begin
        errors++;
        $display("FAIL data_path cyc %0d: got %h expected %h", c, ifa.bus_i, exp_b);
      end
      if (c == 2) ifa.req = 4'b0000;
    end
  endtask

  task automatic test_force_z();
    logic [13:0] act;
    logic [3:0]  exp_g;
    do_reset();
    ifa.req = 4'b0011;
    ifa.din = $urandom;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_g = (c < 2) ? 4'b0001 : (c < 7) ? 4'b0000 : 4'b0010;
      checks++;
      if (ifa.gnt !== exp_g || ifa.bus_t !== (exp_g == 4'b0000)) begin
        errors++;
        $display("FAIL force_z cyc %0d: got %b/%b expected %b", c, ifa.gnt, ifa.bus_t, exp_g);
      end
      act = {ifa.gnt, ifa.bus_t, ifa.busy, ifa.bus_i};
      checks++;
      if (act !== expv(ma, ifa.din)) begin
        errors++;
        $display("FAIL force_model cyc %0d: got %h expected %h", c, act, expv(ma, ifa.din));
      end
      if (c == 1) ifa.force_z = 1'b1;
      if (c == 6) ifa.force_z = 1'b0;
    end
  endtask

  task automatic test_unlimited_hold();
    logic [13:0] act;
    do_reset();
    ifb.req = 4'b0001;
    ifb.din = $urandom;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if (ifb.gnt !== 4'b0001) begin
        errors++;
        $display("FAIL unlimited_hold cyc %0d: got %b expected 0001", c, ifb.gnt);
      end
      act = {ifb.gnt, ifb.bus_t, ifb.busy, ifb.bus_i};
      checks++;
      if (act !== expv(mb, ifb.din)) begin
        errors++;
        $display("FAIL unlimited_model cyc %0d: got %h expected %h", c, act, expv(mb, ifb.din));
      end
      ifb.din = $urandom;
    end
    ifb.req = 4'b0000;
    @(negedge clk);
    checks++;
    if (ifb.gnt !== 4'b0000 || ifb.bus_t !== 1'b1 || ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL turn0_gap: got %b/%b/%b expected 0000/1/0", ifb.gnt, ifb.bus_t, ifb.busy);
    end
    ifb.req = 4'b0001;
    @(negedge clk);
    checks++;
    if (ifb.gnt !== 4'b0001 || ifb.bus_t !== 1'b0) begin
      errors++;
      $display("FAIL turn0_regrant: got %b/%b expected 0001/0", ifb.gnt, ifb.bus_t);
    end
  endtask

  task automatic test_random();
    logic [13:0] act;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      act = {ifa.gnt, ifa.bus_t, ifa.busy, ifa.bus_i};
      checks++;
      if (act !== expv(ma, ifa.din)) begin
        errors++;
        $display("FAIL random_a cyc %0d: got %h expected %h", c, act, expv(ma, ifa.din));
      end
      act = {ifb.gnt, ifb.bus_t, ifb.busy, ifb.bus_i};
      checks++;
      if (act !== expv(mb, ifb.din)) begin
        errors++;
        $display("FAIL random_b cyc %0d: got %h expected %h", c, act, expv(mb, ifb.din));
      end
      if ($urandom_range(0, 5) == 0) ifa.req = 4'($urandom);
      if ($urandom_range(0, 5) == 0) ifb.req = 4'($urandom);
      ifa.force_z = ($urandom_range(0, 19) == 0);
      ifb.force_z = ($urandom_range(0, 19) == 0);
      ifa.din     = $urandom;
      ifb.din     = $urandom;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_early_release();
    test_data_path();
    test_force_z();
    test_unlimited_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Shares one tri-state output pad bus (a bank of OBUFT-style buffers with common I/T) between NREQ internal requesters. Grants ownership round-robin, drives the buffer bank's data (BUS_I) and tri-state control (BUS_T, high = high-Z), and enforces a programmable high-Z turnaround gap between owners plus a maximum hold time. Sits between the core logic and the output buffer primitives; the buffers' own global tristate remains independent.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 8: bus data width
- TURN, 1: high-Z turnaround cycles after every release, 0..15
- MAXHOLD, 16: max consecutive DRIVE cycles per grant, 1..255; 0 = unlimited

- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous reset, active low
- REQ  in  NREQ  per-requester bus request, level, held while bus wanted
- DIN  in  NREQ*DW  requester data, slice i = DIN[i*DW +: DW]
- FORCE_Z  in  1  synchronous request to release and hold bus high-Z
- GNT  out  NREQ  one-hot grant, registered
- BUS_I  out  DW  data to buffer I inputs
- BUS_T  out  1  tri-state control to buffer T inputs, 1 = high-Z, registered
- BUSY  out  1  high in DRIVE and TURN states

## Operation
- States: IDLE, DRIVE, TURN. Registers: state, owner index, last-owner pointer, hold counter (8 bit), turn counter (4 bit).
- Reset (async, RST_N low): state IDLE, GNT=0, BUS_T=1, BUSY=0, BUS_I=0, last-owner=NREQ-1 (so requester 0 wins first), counters 0. Takes effect immediately, including mid-DRIVE.
- IDLE: GNT=0, BUS_T=1. If FORCE_Z=0 and any REQ set: select first set REQ scanning last-owner+1, +2, ... modulo NREQ; go DRIVE, GNT[sel]=1, BUS_T=0, owner=sel, last-owner=sel, hold counter=1.
- DRIVE: BUS_I = DIN slice of owner (combinational mux on registered owner); GNT/BUS_T unchanged. Release when any of: REQ[owner]=0, FORCE_Z=1, or MAXHOLD!=0 and hold counter==MAXHOLD. On release: GNT=0, BUS_T=1; go TURN (turn counter=1) if TURN>0, else IDLE. Otherwise hold counter increments (saturating at 255).
- TURN: GNT=0, BUS_T=1, BUSY=1. When turn counter==TURN go IDLE, else increment.
- BUS_I = 0 whenever GNT=0 (never forwards data of a non-owner).
- REQ changes of non-owners during DRIVE/TURN are ignored until IDLE evaluates.
- FORCE_Z held high: arbiter stays/returns to IDLE, BUS_T=1, no grants.
- A requester preempted by MAXHOLD keeping REQ high is re-granted only after all other active requesters (round-robin pointer already advanced to it).

## Timing
- Grant latency: REQ sampled high in IDLE at edge k -> GNT, BUS_T=0 valid after edge k.
- Release latency: REQ[owner] sampled low at edge m -> GNT=0, BUS_T=1 after edge m.
- High-Z gap between consecutive owners: exactly TURN+1 cycles (TURN cycles in TURN, one in IDLE).
- MAXHOLD: with REQ held, owner drives exactly MAXHOLD cycles, then release.
- FORCE_Z sampled high in DRIVE: BUS_T=1 after that edge (1 cycle).
- BUS_I follows DIN of owner combinationally in DRIVE; zero-cycle data path.
- Invariant: at most one GNT bit set; BUS_T==~|GNT at all times.

## Test plan
- Reset: RST_N low mid-DRIVE with REQ=4'b0001 -> BUS_T=1, GNT=0 immediately; after release with REQ=4'b0001, GNT=4'b0001 one cycle later.
- Round-robin: REQ=4'b1111 continuously, MAXHOLD=16, TURN=1 -> grants 0,1,2,3,0 each 16 cycles, 2 high-Z cycles between.
- Early release: owner 2 drops REQ after 3 cycles, REQ[3] pending -> GNT[2] 3 cycles, BUS_T=1 for TURN+1=2 cycles, then GNT=4'b1000.
- Data path: owner 1, DIN slice1=8'hA5, others 8'hFF -> BUS_I=8'hA5 in DRIVE, 8'h00 in TURN/IDLE.
- FORCE_Z: asserted in DRIVE for 5 cycles with REQ=4'b0011 -> BUS_T=1 next cycle, no grant for 5 cycles, grant resumes round-robin after deassert.
- TURN=0, MAXHOLD=0 build: single requester toggling REQ -> 1-cycle IDLE gap, unlimited hold verified over 300 cycles.
